// File: rtl/activation_pkg.sv
// Shared types and constants for the activation pipeline.
//   act_func_e       : per-beat activation mode encoding (5-7 are illegal)
//   ACT_FUNC_W       : width of the func field
//   act_func_legal() : true for the five defined modes
package activation_pkg;

  localparam int unsigned ACT_FUNC_W = 3;

  typedef enum logic [ACT_FUNC_W-1:0] {
    ACT_RELU     = 3'd0,
    ACT_BINARY   = 3'd1,
    ACT_IDENTITY = 3'd2,
    ACT_LEAKY    = 3'd3,
    ACT_CLAMP    = 3'd4
  } act_func_e;

  function automatic logic act_func_legal(input logic [ACT_FUNC_W-1:0] f);
    return f <= ACT_CLAMP;
  endfunction

endpackage

// File: rtl/activation_lane.sv
// Single-lane combinational activation function.
//   func : activation mode (act_func_e encoding; 5-7 yield 0)
//   x    : signed lane input
//   y    : activated lane output
module activation_lane
  import activation_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned LEAKY_SHIFT = 1,
  parameter int unsigned CLAMP_MAX   = 127
) (
  input  logic [ACT_FUNC_W-1:0] func,
  input  logic signed [DW-1:0]  x,
  output logic signed [DW-1:0]  y
);

  localparam logic [DW-1:0] ClampVal = DW'(CLAMP_MAX);

  logic sign;
  assign sign = x[DW-1];

  always_comb begin
    y = '0;
    case (func)
      ACT_RELU:     y = sign ? '0 : x;
      ACT_BINARY:   y = sign ? '0 : DW'(1);
      ACT_IDENTITY: y = x;
      ACT_LEAKY:    y = sign ? (x >>> LEAKY_SHIFT) : x;
      // Only reached for non-negative x, so an unsigned compare is exact.
      ACT_CLAMP:    y = sign ? '0 : (($unsigned(x) > ClampVal) ? ClampVal : x);
      default:      y = '0;
    endcase
  end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage valid/ready activation pipeline over LANES signed lanes.
// Stage 1 registers the input beat and mode, stage 2 registers the
// activated lanes. Output beats are counted per frame of FRAME_LEN.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : input handshake; func and bias_output ride with it
//   out_valid/ready : output handshake; activation_out, out_last ride with it
//   func_err        : sticky flag, an illegal func beat was accepted
// Optional (ACTIVATION_PIPE_STATS_EN):
//   stats_clr       : synchronous clear of zero_cnt (wins over increment)
//   zero_cnt        : saturating count of zero lanes in transferred beats
module activation_pipe
  import activation_pkg::*;
#(
  parameter int unsigned LANES       = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned LEAKY_SHIFT = 1,
  parameter int unsigned CLAMP_MAX   = 127,
  parameter int unsigned FRAME_LEN   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACT_FUNC_W-1:0] func,
  input  logic [LANES*DW-1:0]   bias_output,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   activation_out,
  output logic                  out_last,
  output logic                  func_err
`ifdef ACTIVATION_PIPE_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [31:0]           zero_cnt
`endif
);

  localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(FRAME_LEN - 1);

  logic                  s1_valid_q, s2_valid_q;
  logic                  s1_adv, s2_adv;
  logic                  in_xfer, out_xfer;
  logic [ACT_FUNC_W-1:0] s1_func_q;
  logic [LANES*DW-1:0]   s1_data_q;
  logic [LANES*DW-1:0]   act_d, act_q;
  logic [CntW-1:0]       beat_cnt_q;
  logic                  func_err_q;

  // A stage may load when it is empty or its content leaves this cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = s2_valid_q && out_ready;

  assign out_valid      = s2_valid_q;
  assign activation_out = act_q;
  assign out_last       = s2_valid_q && (beat_cnt_q == LastBeat);
  assign func_err       = func_err_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    activation_lane #(
      .DW          (DW),
      .LEAKY_SHIFT (LEAKY_SHIFT),
      .CLAMP_MAX   (CLAMP_MAX)
    ) u_lane (
      .func (s1_func_q),
      .x    (s1_data_q[DW*i +: DW]),
      .y    (act_d[DW*i +: DW])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_func_q  <= '0;
      s1_data_q  <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_func_q <= func;
        s1_data_q <= bias_output;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      act_q      <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        act_q <= act_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (out_xfer) begin
      beat_cnt_q <= (beat_cnt_q == LastBeat) ? '0 : beat_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_err_q <= 1'b0;
    end else if (in_xfer && !act_func_legal(func)) begin
      func_err_q <= 1'b1;
    end
  end

`ifdef ACTIVATION_PIPE_STATS_EN
  localparam int unsigned ZeroW = $clog2(LANES + 1);

  logic [ZeroW-1:0] zero_lanes;
  logic [32:0]      zero_sum;
  logic [31:0]      zero_cnt_q;

  always_comb begin
    zero_lanes = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (act_q[DW*i +: DW] == '0) begin
        zero_lanes = zero_lanes + ZeroW'(1);
      end
    end
  end

  assign zero_sum = {1'b0, zero_cnt_q} + 33'(zero_lanes);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt_q <= '0;
    end else if (stats_clr) begin
      zero_cnt_q <= '0;
    end else if (out_xfer) begin
      zero_cnt_q <= zero_sum[32] ? '1 : zero_sum[31:0];
    end
  end

  assign zero_cnt = zero_cnt_q;
`endif

endmodule

// File: tb/tb_activation_pipe.sv
// Self-checking bench for activation_pipe (CLAMP_MAX=0x20, FRAME_LEN=4).
module tb_activation_pipe;

  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int LS    = 1;
  localparam int CM    = 32;
  localparam int FL    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_func;
  logic [LANES*DW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LANES*DW-1:0] activation_out;
  logic              out_last;
  logic              func_err;
  logic              stats_clr;
  logic [31:0]       zero_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  activation_pipe #(
    .LANES       (LANES),
    .DW          (DW),
    .LEAKY_SHIFT (LS),
    .CLAMP_MAX   (CM),
    .FRAME_LEN   (FL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .func           (in_func),
    .bias_output    (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .activation_out (activation_out),
    .out_last       (out_last),
    .func_err       (func_err)
`ifdef ACTIVATION_PIPE_STATS_EN
    ,
    .stats_clr      (stats_clr),
    .zero_cnt       (zero_cnt)
`endif
  );

`ifndef ACTIVATION_PIPE_STATS_EN
  assign zero_cnt = '0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: each lane evaluated with integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] d);
    logic [63:0] o;
    logic signed [7:0] b;
    int v, r;
    o = '0;
    for (int i = 0; i < LANES; i++) begin
      b = d[8*i +: 8];
      v = b;
      case (f)
        3'd0: r = (v < 0) ? 0 : v;
        3'd1: r = (v < 0) ? 0 : 1;
        3'd2: r = v;
        3'd3: r = (v < 0) ? -((-v + (1 << LS) - 1) / (1 << LS)) : v;
        3'd4: r = (v < 0) ? 0 : ((v > CM) ? CM : v);
        default: r = 0;
      endcase
      o[8*i +: 8] = r[7:0];
    end
    return o;
  endfunction

  function automatic int zeros_in(input logic [63:0] d);
    int z = 0;
    for (int i = 0; i < LANES; i++) if (d[8*i +: 8] == 8'h00) z++;
    return z;
  endfunction

  // Scoreboard / monitor, sampled mid-cycle.
  logic [63:0] exp_q[$];
  int          out_beats;
  int          last_idx[$];
  logic        stalled;
  logic [63:0] stall_data;
  logic        stall_last;
  longint      zmodel;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_idx.delete();
      out_beats = 0;
      stalled   = 1'b0;
      zmodel    = 0;
    end else begin
      if (stalled) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_data", activation_out, stall_data);
        check("stall_last", {63'd0, out_last}, {63'd0, stall_last});
      end
      if (!out_valid) check("last_idle", {63'd0, out_last}, 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          check("sb_data", activation_out, exp_q[0]);
          check("sb_last", {63'd0, out_last},
                {63'd0, (out_beats % FL) == FL - 1});
          if (stats_clr) zmodel = 0;
          else zmodel = zmodel + zeros_in(exp_q[0]);
          void'(exp_q.pop_front());
        end
        out_beats++;
        if (out_last) last_idx.push_back(out_beats);
      end else if (stats_clr) begin
        zmodel = 0;
      end
      stalled    = out_valid && !out_ready;
      stall_data = activation_out;
      stall_last = out_last;
      if (in_valid && in_ready) exp_q.push_back(model(in_func, in_data));
    end
  end

  typedef struct {
    logic [2:0]  func;
    logic [63:0] data;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] sweep;
  logic        pat[4];

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int c = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && c < 40) begin
      @(posedge clk);
      #1 c++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_func = '0; in_data = '0;
    out_ready = 1'b1; stats_clr = 1'b0;
    sweep = {8'h81, 8'hC0, 8'h40, 8'h7F, 8'h01, 8'h00, 8'hFF, 8'h80};
    vecs[0] = '{3'd0, sweep, {8'h00, 8'h00, 8'h40, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h00}, 1'b0};
    vecs[1] = '{3'd1, sweep, {8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00}, 1'b0};
    vecs[2] = '{3'd2, sweep, sweep, 1'b0};
    vecs[3] = '{3'd3, sweep, {8'hC0, 8'hE0, 8'h40, 8'h7F, 8'h01, 8'h00, 8'hFF, 8'hC0}, 1'b0};
    vecs[4] = '{3'd4, sweep, {8'h00, 8'h00, 8'h20, 8'h20, 8'h01, 8'h00, 8'h00, 8'h00}, 1'b0};
    vecs[5] = '{3'd6, sweep, 64'd0, 1'b1};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state.
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_act_out", activation_out, 64'd0);
    check("rst_func_err", {63'd0, func_err}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Function sweep, one beat at a time, with exact N+2 latency.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 in_valid = 1'b1; in_func = vecs[k].func; in_data = vecs[k].data;
      check("sweep_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("sweep_lat_n1", {63'd0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      check("sweep_lat_n2", {63'd0, out_valid}, 64'd1);
      check($sformatf("sweep_mode%0d", vecs[k].func), activation_out, vecs[k].exp);
      check("sweep_func_err", {63'd0, func_err}, {63'd0, vecs[k].err});
    end
    @(posedge clk);
    #1;

    // Reset mid-stream with two beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_func = 3'd2; in_data = 64'h0102030405060708;
    @(posedge clk);
    #1 in_data = 64'h1112131415161718;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("pre_rst_func_err", {63'd0, func_err}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_act_out", activation_out, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_func_err", {63'd0, func_err}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 check("no_stale_beat", {63'd0, out_valid}, 64'd0);
    end

    // Full-flow stream of 10 beats: throughput, latency and frame marking.
    in_valid = 1'b1; in_func = 3'($urandom_range(0, 4)); in_data = {$urandom, $urandom};
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check("flow_in_ready", {63'd0, in_ready}, 64'd1);
      check("flow_out_valid", {63'd0, out_valid}, {63'd0, (k >= 2) && (k <= 11)});
      if (k < 10) begin
        in_func = 3'($urandom_range(0, 4));
        in_data = {$urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
    end
    check("frame_last_count", 64'(last_idx.size()), 64'd2);
    if (last_idx.size() == 2) begin
      check("frame_last_a", 64'(last_idx[0]), 64'd4);
      check("frame_last_b", 64'(last_idx[1]), 64'd8);
    end

    // Backpressure: 6 beats while out_ready follows 1,0,0,1.
    begin
      int acc = 0;
      in_func = 3'($urandom_range(0, 4)); in_data = {$urandom, $urandom};
      for (int c = 0; c < 60 && acc < 6; c++) begin
        out_ready = pat[c % 4];
        in_valid  = 1'b1;
        #1;
        if (in_ready) acc++;
        @(posedge clk);
        #1;
        if (in_ready && out_ready == pat[c % 4]) begin
          in_func = 3'($urandom_range(0, 4)); in_data = {$urandom, $urandom};
        end
      end
      in_valid = 1'b0;
      check("bp_accepted", 64'(acc), 64'd6);
      drain("bp_drain");
    end

    // Stats: zero-lane counting and synchronous clear.
    do_reset();
    check("stats_rst", {32'd0, zero_cnt}, 64'd0);
`ifdef ACTIVATION_PIPE_STATS_EN
    @(posedge clk);
    #1 in_valid = 1'b1; in_func = 3'd0;
    in_data = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hC0, 8'hFF, 8'h80};
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 check("stats_count", {32'd0, zero_cnt}, 64'd3);
    stats_clr = 1'b1;
    @(posedge clk);
    #1 stats_clr = 1'b0;
    check("stats_clear", {32'd0, zero_cnt}, 64'd0);
`endif

    // Randomised traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_func  = 3'($urandom_range(0, 7));
        in_data  = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    drain("rand_drain");
    check("rand_func_err_sticky", {63'd0, func_err}, 64'd1);
`ifdef ACTIVATION_PIPE_STATS_EN
    check("rand_zero_cnt", {32'd0, zero_cnt}, 64'(zmodel));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/activation_pipe.md
Name: activation_pipe

Overview:
- Parametrised successor to the fixed 8-lane activation stage.
- Applies one of five per-lane activation functions to a packed vector of signed bias-adder results.
- Two-stage valid/ready pipeline with backpressure; tracks output beats per frame and flags the last beat.
- Sits between the bias adder and the output buffer / next-layer feeder of the systolic array datapath.

Parameters:
- LANES, 8, number of parallel lanes
- DW, 8, lane width in bits (signed two's complement)
- LEAKY_SHIFT, 1, arithmetic right shift applied to negative lanes in leaky ReLU
- CLAMP_MAX, 127, upper clamp for mode 4; must be within 0 to 2^(DW-1)-1
- FRAME_LEN, 16, output beats per frame; must be at least 1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- func  in  3  mode, sampled with the beat: 0 ReLU, 1 binary, 2 identity, 3 leaky ReLU, 4 clamp; 5-7 illegal
- bias_output  in  LANES*DW  packed lanes, lane i at bits [DW*i+DW-1 : DW*i]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output beat
- activation_out  out  LANES*DW  packed activated lanes
- out_last  out  1  current output beat is the last beat of its frame
- func_err  out  1  sticky: an illegal func was accepted

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: s1_valid=0, s2_valid=0, activation_out=0, beat_cnt=0, func_err=0.
  - Hence out_valid=0, out_last=0, in_ready=1.
- Reset asserted mid-operation discards all in-flight beats immediately.
- Stage 1 registers bias_output and func.
- Stage 2 registers the computed activation.
- Latency: a beat accepted in cycle N appears at out_valid in cycle N+2 when no stall occurs.
- Handshake:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv, combinational from out_ready and valid flags only; never depends on in_valid.
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Throughput is 1 beat/cycle at full flow; no bubbles are inserted.
  - While out_valid=1 and out_ready=0, activation_out and out_last hold stable.
- Per-lane function; x is the lane value and sign is its MSB:
  - 0 ReLU: sign ? 0 : x.
  - 1 binary: sign ? 0 : 1. Zero maps to 1.
  - 2 identity: x.
  - 3 leaky: sign ? (x >>> LEAKY_SHIFT) : x, sign-extended arithmetic shift. -1 stays -1; -128 >>> 1 = -64.
  - 4 clamp: sign ? 0 : (x > CLAMP_MAX ? CLAMP_MAX : x).
  - 5-7: lanes output 0 and the beat still flows.
- func_err sets when an illegal func beat is accepted into stage 1 and clears only on reset.
- Frame counter:
  - beat_cnt, width $clog2(FRAME_LEN) with a minimum of 1, increments on each output transfer.
  - Wraps to 0 after FRAME_LEN-1.
  - out_last = out_valid & (beat_cnt == FRAME_LEN-1).
  - FRAME_LEN=1 makes every beat last.
- Simultaneous input and output transfer in the same cycle at full pipeline is legal and loses no data.

Optional Feature:
- Macro: ACTIVATION_PIPE_STATS_EN.
- When defined:
  - Adds output zero_cnt, width 32, which counts lanes equal to 0 in each transferred output beat.
  - Adds input stats_clr, width 1, a synchronous clear that has priority over the same-cycle increment.
  - zero_cnt saturates at 2^32-1 and resets to 0.
- When not defined:
  - Neither port exists and no counter logic is synthesised.
  - Core behaviour is identical in both builds.

Decomposition:
- Package activation_pkg holds:
  - the enum act_func_e with ACT_RELU=0, ACT_BINARY=1, ACT_IDENTITY=2, ACT_LEAKY=3, ACT_CLAMP=4
  - the constant ACT_FUNC_W=3
- One sub-module, activation_lane: combinational single-lane function parameterised by DW, LEAKY_SHIFT and CLAMP_MAX.
  - Instantiated LANES times in a generate loop.
  - Pipeline, handshake and counters live in the top level.

Test Plan:
- Reset: assert rst mid-stream with 2 beats in flight -> out_valid=0, activation_out=0, in_ready=1 immediately; no stale beat after release.
- Function sweep: lanes {0x80,0xFF,0x00,0x01,0x7F,0x40,0xC0,0x81}, func 0..4 -> mode0 {0,0,0,1,7F,40,0,0}; mode1 {0,0,1,1,1,1,0,0}; mode2 unchanged; mode3 {C0,FF,0,1,7F,40,E0,C0}; mode4 with CLAMP_MAX=0x20 {0,0,0,1,20,20,0,0}.
- Backpressure: stream 6 beats while out_ready toggles 1,0,0,1 -> all 6 delivered in order, outputs stable during stalls; with out_ready=1 and a continuous stream, 1 beat/cycle and first output at cycle N+2.
- Frame: FRAME_LEN=4, 10 beats -> out_last on beats 4 and 8 only; counter does not advance during stalls.
- Illegal func: beat with func=6 -> lanes 0, func_err=1 and stays 1 until reset.
- Stats build: beat of mode0 with 3 negative lanes, then stats_clr -> zero_cnt 3, then 0 on the next cycle.
